// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares the cartridge SDRAM port between CHR fetch, PRG access and the loader.
// Ports:
//   clk_i, reset_n_i                    clock, synchronous active-low reset
//   chr_req_i/chr_addr_i                CHR read request pulse and address
//   chr_rdata_o/chr_done_o              CHR read data and completion pulse
//   prg_req_i/prg_addr_i/prg_we_i/prg_wdata_i  PRG request pulse, address, direction, write data
//   prg_rdata_o/prg_done_o              PRG read data and completion pulse
//   ld_req_i/ld_addr_i/ld_wdata_i       loader write request pulse, address, data
//   ld_done_o                           loader completion pulse
//   mem_req_o/mem_addr_o/mem_we_o/mem_wdata_o  memory request, held until mem_ack_i
//   mem_ack_i/mem_rdata_i               memory acknowledge with same-cycle read data
//   ovf_o                               sticky: request pulse hit a still-pending slot
module cart_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW = 22
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          chr_req_i,
    input  logic [AW-1:0] chr_addr_i,
    output logic [7:0]    chr_rdata_o,
    output logic          chr_done_o,
    input  logic          prg_req_i,
    input  logic [AW-1:0] prg_addr_i,
    input  logic          prg_we_i,
    input  logic [7:0]    prg_wdata_i,
    output logic [7:0]    prg_rdata_o,
    output logic          prg_done_o,
    input  logic          ld_req_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [7:0]    ld_wdata_i,
    output logic          ld_done_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [7:0]    mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [7:0]    mem_rdata_i,
    output logic          ovf_o
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e        state_q;
    logic [2:0]    req, acc, cmp, pend_q, pend_d, we_q, in_we, we_e, done_q;
    logic [AW-1:0] in_addr [3];
    logic [AW-1:0] addr_q [3];
    logic [AW-1:0] addr_e [3];
    logic [7:0]    in_wdata [3];
    logic [7:0]    wdata_q [3];
    logic [7:0]    wdata_e [3];
    logic [1:0]    gnt_q, win;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack, grant, force_ld, ovf_q, mem_req_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [7:0]    mem_wdata_q, chr_rdata_q, prg_rdata_q;

    // Slot index: 0 = CHR, 1 = PRG, 2 = loader
    assign req         = {ld_req_i, prg_req_i, chr_req_i};
    assign in_addr[0]  = chr_addr_i;
    assign in_addr[1]  = prg_addr_i;
    assign in_addr[2]  = ld_addr_i;
    assign in_wdata[0] = 8'h00;
    assign in_wdata[1] = prg_wdata_i;
    assign in_wdata[2] = ld_wdata_i;
    assign in_we       = {1'b1, prg_we_i, 1'b0};
    assign ack         = state_q == BUSY && mem_ack_i;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cmp[i]     = ack && gnt_q == 2'(i);
            // A completing slot is free again, so a pulse on that same edge refills it
            acc[i]     = req[i] && (!pend_q[i] || cmp[i]);
            pend_d[i]  = acc[i] || (pend_q[i] && !cmp[i]);
            // Freshly captured requests are eligible on the capture edge
            addr_e[i]  = acc[i] ? in_addr[i] : addr_q[i];
            we_e[i]    = acc[i] ? in_we[i] : we_q[i];
            wdata_e[i] = acc[i] ? in_wdata[i] : wdata_q[i];
        end
        force_ld = pend_d[2] && cnt_q >= CW'(STARVE_MAX);
        win      = force_ld ? 2'd2 : pend_d[0] ? 2'd0 : pend_d[1] ? 2'd1 : 2'd2;
        grant    = state_q == IDLE && |pend_d;
        cnt_d    = (!pend_d[2] || (grant && win == 2'd2)) ? '0 : grant ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            we_q        <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            done_q      <= '0;
            ovf_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            chr_rdata_q <= '0;
            prg_rdata_q <= '0;
            for (int i = 0; i < 3; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_q || |(req & pend_q & ~cmp);
            done_q <= ack ? 3'b001 << gnt_q : 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    addr_q[i]  <= in_addr[i];
                    we_q[i]    <= in_we[i];
                    wdata_q[i] <= in_wdata[i];
                end
            end
            if (grant) begin
                state_q     <= BUSY;
                gnt_q       <= win;
                mem_req_q   <= 1'b1;
                mem_addr_q  <= addr_e[win];
                mem_we_q    <= we_e[win];
                mem_wdata_q <= wdata_e[win];
            end
            if (ack) begin
                state_q   <= IDLE;
                mem_req_q <= 1'b0;
                if (gnt_q == 2'd0) chr_rdata_q <= mem_rdata_i;
                if (gnt_q == 2'd1 && !mem_we_q) prg_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign chr_done_o  = done_q[0];
    assign prg_done_o  = done_q[1];
    assign ld_done_o   = done_q[2];
    assign chr_rdata_o = chr_rdata_q;
    assign prg_rdata_o = prg_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign ovf_o       = ovf_q;
endmodule
